// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and machine word type.
package y86_pkg;

    localparam int WORD_W = 64;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

endpackage

// File: rtl/y86_data_memory.sv
// Byte-addressed little-endian data memory: 8-byte combinational read,
// 8-byte synchronous write, whole-array asynchronous clear.
module y86_data_memory
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] addr,
    input  word_t             writeData,
    output word_t             readData
);

    logic [7:0] mem [MEM_BYTES];

    // Caller guarantees addr <= MEM_BYTES-8, so addr+7 never wraps or overruns.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_readLane
            assign readData[8*gi +: 8] = mem[addr + ADDR_W'(gi)];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (writeEn) begin
            for (int b = 0; b < 8; b++) begin
                mem[addr + ADDR_W'(b)] <= writeData[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/y86_memory_access.sv
// Y86-64 memory stage: decodes icode into read/write, selects address and
// write data, range-checks the access and drives valM / dmem_error.
module y86_memory_access
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] icode_i,
    input  word_t      valE_i,
    input  word_t      valA_i,
    input  word_t      valP_i,
    output word_t      valM_o,
    output logic       dmem_error_o
);

    localparam int    ADDR_W   = $clog2(MEM_BYTES);
    localparam word_t MAX_ADDR = word_t'(MEM_BYTES - 8);

    logic              memRead;
    logic              memWrite;
    word_t             accessAddr;
    word_t             accessData;
    logic              inRange;
    logic [ADDR_W-1:0] memAddr;
    word_t             readData;

    always_comb begin
        memRead    = 1'b0;
        memWrite   = 1'b0;
        accessAddr = valE_i;
        accessData = valA_i;
        case (icode_i)
            ICODE_RMMOVQ, ICODE_PUSHQ: memWrite = 1'b1;
            ICODE_CALL: begin
                memWrite   = 1'b1;
                accessData = valP_i;
            end
            ICODE_MRMOVQ: memRead = 1'b1;
            ICODE_POPQ, ICODE_RET: begin
                memRead    = 1'b1;
                accessAddr = valA_i;
            end
            default: ;
        endcase
    end

    // Comparing the start address avoids the addr+7 overflow an end-address check would have.
    assign inRange      = (accessAddr <= MAX_ADDR);
    assign dmem_error_o = (memRead | memWrite) & ~inRange;
    assign memAddr      = inRange ? accessAddr[ADDR_W-1:0] : '0;
    assign valM_o       = (memRead & inRange) ? readData : '0;

    y86_data_memory #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W)
    ) u_dataMemory (
        .clk      (clk_i),
        .rst      (rst_i),
        .writeEn  (memWrite & inRange),
        .addr     (memAddr),
        .writeData(accessData),
        .readData (readData)
    );

endmodule

// File: tb/tb_y86_memory_access.sv
// Directed self-checking bench for the Y86-64 memory stage.
module tb_y86_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic [63:0] valM;
    logic        dmemError;

    int vectors     = 0;
    int miscompares = 0;

    y86_memory_access dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .icode_i     (icode),
        .valE_i      (valE),
        .valA_i      (valA),
        .valP_i      (valP),
        .valM_o      (valM),
        .dmem_error_o(dmemError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
            $display("vec %0d %s ok value=%h", vectors, tag, obs);
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-cycle so they settle well away from the rising edge.
    task automatic apply(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p);
        @(negedge clk);
        icode = ic;
        valE  = e;
        valA  = a;
        valP  = p;
        #1;
    endtask

    task automatic read8(input string tag, input logic [63:0] addr, input logic [63:0] expData,
                         input logic expErr);
        apply(4'h5, addr, 64'h0, 64'h0);
        check({tag, "_valM"}, valM, expData);
        check({tag, "_err"}, {63'b0, dmemError}, {63'b0, expErr});
    endtask

    task automatic write8(input logic [3:0] ic, input logic [63:0] addr, input logic [63:0] a,
                          input logic [63:0] p);
        apply(ic, addr, a, p);
        @(posedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        icode = 4'h1;
        valE  = '0;
        valA  = '0;
        valP  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        read8("reset_read3", 64'd3, 64'h0, 1'b0);

        // Write then unaligned reads
        apply(4'h4, 64'd3, 64'h1122334455667788, 64'h0);
        check("rmmovq_valM_zero", valM, 64'h0);
        check("rmmovq_err", {63'b0, dmemError}, 64'h0);
        @(posedge clk);
        read8("read3", 64'd3, 64'h1122334455667788, 1'b0);
        read8("read4", 64'd4, 64'h0011223344556677, 1'b0);
        apply(4'h9, 64'd100, 64'd3, 64'h0);
        check("ret_valA_addr", valM, 64'h1122334455667788);

        // Call writes valP, push writes valA
        write8(4'h8, 64'd16, 64'h99, 64'h4);
        read8("call_data", 64'd16, 64'h4, 1'b0);
        write8(4'hA, 64'd24, 64'h2, 64'h0);
        read8("push_data", 64'd24, 64'h2, 1'b0);

        // Upper boundary
        write8(4'h4, 64'd1016, 64'hA5A5_0102_0304_5A5A, 64'h0);
        read8("top_ok", 64'd1016, 64'hA5A5_0102_0304_5A5A, 1'b0);
        read8("top_plus1", 64'd1017, 64'h0, 1'b1);
        apply(4'h4, 64'd1017, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0);
        check("oor_write_err", {63'b0, dmemError}, 64'h1);
        @(posedge clk);
        read8("oor_write_nochange", 64'd1016, 64'hA5A5_0102_0304_5A5A, 1'b0);
        read8("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        apply(4'hB, 64'd0, 64'd1024, 64'h0);
        check("popq_oor_err", {63'b0, dmemError}, 64'h1);
        check("popq_oor_valM", valM, 64'h0);

        // Non-memory icodes never access or flag
        apply(4'h6, 64'd2000, 64'h77, 64'h0);
        check("opq_err", {63'b0, dmemError}, 64'h0);
        check("opq_valM", valM, 64'h0);
        write8(4'h6, 64'd16, 64'h77, 64'h77);
        read8("opq_nowrite", 64'd16, 64'h4, 1'b0);
        apply(4'h0, 64'd2000, 64'd16, 64'h0);
        check("halt_err", {63'b0, dmemError}, 64'h0);
        check("halt_valM", valM, 64'h0);
        apply(4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0);
        check("icodeF_err", {63'b0, dmemError}, 64'h0);

        // popq reads through valA
        write8(4'h4, 64'd40, 64'h0BAD_F00D_1234_5678, 64'h0);
        apply(4'hB, 64'd0, 64'd40, 64'h0);
        check("popq_valA_addr", valM, 64'h0BAD_F00D_1234_5678);

        // Asynchronous reset mid-cycle
        write8(4'h4, 64'd8, 64'h0102_0304_0506_0708, 64'h0);
        read8("pre_reset8", 64'd8, 64'h0102_0304_0506_0708, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_clear8", valM, 64'h0);
        check("reset_err_pure", {63'b0, dmemError}, 64'h0);
        write8(4'h4, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        read8("reset_write_blocked", 64'd8, 64'h0, 1'b0);
        apply(4'h4, 64'd1017, 64'h0, 64'h0);
        check("reset_oor_err", {63'b0, dmemError}, 64'h1);
        @(negedge clk);
        rst = 1'b0;
        read8("post_reset8", 64'd8, 64'h0, 1'b0);
        read8("post_reset16", 64'd16, 64'h0, 1'b0);
        read8("post_reset1016", 64'd1016, 64'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
